// File: rtl/ir_pkg.sv
// Shared NEC receiver constants: tick rate, phase-window limits in 10 us
// ticks, the FSM state encoding and a window-compare helper.
package ir_pkg;

   localparam int TICK_HZ    = 100_000;
   localparam int CNT_W      = 11;
   localparam int FRAME_BITS = 32;

   typedef logic [CNT_W-1:0] cnt_t;

   localparam cnt_t CNT_MAX    = '1;
   localparam cnt_t LEAD_L_MIN = 11'd800;
   localparam cnt_t LEAD_L_MAX = 11'd1000;
   localparam cnt_t LEAD_H_MIN = 11'd400;
   localparam cnt_t LEAD_H_MAX = 11'd500;
   localparam cnt_t REP_H_MIN  = 11'd180;
   localparam cnt_t REP_H_MAX  = 11'd280;
   localparam cnt_t BURST_MIN  = 11'd40;
   localparam cnt_t BURST_MAX  = 11'd70;
   localparam cnt_t ONE_MIN    = 11'd140;
   localparam cnt_t ONE_MAX    = 11'd190;
   localparam cnt_t TIMEOUT    = 11'd1100;

   typedef enum logic [2:0] {
      IDLE,
      LEAD_L,
      LEAD_H,
      BIT_L,
      BIT_H,
      STOP,
      REP_STOP
   } state_e;

   function automatic logic in_win(input cnt_t c, input cnt_t lo, input cnt_t hi);
      return (c >= lo) && (c <= hi);
   endfunction

endpackage

// File: rtl/ir_tick_gen.sv
// 10 us tick prescaler. Restarting on every IR edge keeps the phase
// measurement aligned to the edge instead of a free-running grid.
module ir_tick_gen #(
   parameter int DIV = 500
) (
   input  logic clk,
   input  logic rst_n,
   input  logic restart_i,
   output logic tick_o
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   // Next prescaler count: clear on restart or wrap, otherwise advance.
   always_comb begin
      cnt_d = cnt_q + CW'(1);
      if (restart_i || (cnt_q == LAST)) begin
         cnt_d = '0;
      end
   end

   // Prescaler register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick_o = !restart_i && (cnt_q == LAST);

endmodule

// File: rtl/ir_nec_rx.sv
// NEC IR frame receiver: synchronizes the demodulator output, times each
// low/high phase in 10 us ticks and decodes address/command frames and
// repeat frames.
module ir_nec_rx
   import ir_pkg::*;
#(
   parameter int CLK_HZ    = 50_000_000,
   parameter int REPEAT_EN = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ir_in,
   output logic [7:0] order,
   output logic       order_en,
   output logic [7:0] ir_addr,
   output logic       rx_err
);

   localparam int DIV = (CLK_HZ / TICK_HZ > 0) ? (CLK_HZ / TICK_HZ) : 1;

   logic [1:0] rst_sync_q;
   logic       rst_int_n;
   logic [1:0] ir_sync_q;
   logic       ir_prev_q;
   logic       fall_edge, rise_edge, any_edge;
   logic       tick;
   cnt_t       cnt_q, cnt_d;
   state_e     state_q, state_d;
   logic [4:0] bit_cnt_q, bit_cnt_d;
   logic [FRAME_BITS-1:0] shift_q, shift_d;
   logic [7:0] order_q, order_d, addr_q, addr_d;
   logic       order_en_q, order_en_d, rx_err_q, rx_err_d;
   logic       hist_q, hist_d;
   logic       abort;
   logic       frame_ok;

   // Reset synchronizer: assert asynchronously, release on clk.
   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values, whatever the block order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rst_sync_q <= 2'b00;
      end else begin
         rst_sync_q <= {rst_sync_q[0], 1'b1};
      end
   end

   assign rst_int_n = rst_sync_q[1];

   // Two-flop input synchronizer plus previous-sample flop for edge detection.
   always_ff @(posedge clk or negedge rst_int_n) begin
      if (!rst_int_n) begin
         ir_sync_q <= 2'b11;
         ir_prev_q <= 1'b1;
      end else begin
         ir_sync_q <= {ir_sync_q[0], ir_in};
         ir_prev_q <= ir_sync_q[1];
      end
   end

   assign fall_edge = ir_prev_q & ~ir_sync_q[1];
   assign rise_edge = ~ir_prev_q & ir_sync_q[1];
   assign any_edge  = fall_edge | rise_edge;

   ir_tick_gen #(
      .DIV (DIV)
   ) u_tick (
      .clk       (clk),
      .rst_n     (rst_int_n),
      .restart_i (any_edge),
      .tick_o    (tick)
   );

   // Phase length counter: clears on every edge, saturates at full scale.
   // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
   always_comb begin
      cnt_d = cnt_q;
      if (any_edge) begin
         cnt_d = '0;
      end else if (tick && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + cnt_t'(1);
      end
   end

   // Address and command bytes must each be followed by their complement.
   assign frame_ok = (shift_q[15:8] == ~shift_q[7:0]) &&
                     (shift_q[31:24] == ~shift_q[23:16]);

   // Frame FSM: next state, shift/bit datapath and output strobes.
   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      order_d    = order_q;
      addr_d     = addr_q;
      hist_d     = hist_q;
      order_en_d = 1'b0;
      rx_err_d   = 1'b0;
      abort      = 1'b0;

      // A stalled phase wins over any coincident edge; that edge is dropped.
      if ((state_q != IDLE) && (cnt_q >= TIMEOUT)) begin
         abort = 1'b1;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (fall_edge) begin
                  state_d   = LEAD_L;
                  bit_cnt_d = '0;
                  shift_d   = '0;
               end
            end
            LEAD_L: begin
               if (rise_edge) begin
                  if (in_win(cnt_q, LEAD_L_MIN, LEAD_L_MAX)) state_d = LEAD_H;
                  else                                         abort   = 1'b1;
               end else if (fall_edge) begin
                  abort = 1'b1;
               end
            end
            LEAD_H: begin
               if (fall_edge) begin
                  if      (in_win(cnt_q, LEAD_H_MIN, LEAD_H_MAX)) state_d = BIT_L;
                  else if (in_win(cnt_q, REP_H_MIN, REP_H_MAX))   state_d = REP_STOP;
                  else                                            abort   = 1'b1;
               end else if (rise_edge) begin
                  abort = 1'b1;
               end
            end
            BIT_L: begin
               if (rise_edge) begin
                  if (in_win(cnt_q, BURST_MIN, BURST_MAX)) state_d = BIT_H;
                  else                                      abort   = 1'b1;
               end else if (fall_edge) begin
                  abort = 1'b1;
               end
            end
            BIT_H: begin
               if (fall_edge) begin
                  if (in_win(cnt_q, BURST_MIN, BURST_MAX) || in_win(cnt_q, ONE_MIN, ONE_MAX)) begin
                     // LSB-first: each new bit enters at the top and moves down.
                     shift_d   = {in_win(cnt_q, ONE_MIN, ONE_MAX), shift_q[FRAME_BITS-1:1]};
                     bit_cnt_d = bit_cnt_q + 5'd1;
                     state_d   = (bit_cnt_q == 5'(FRAME_BITS - 1)) ? STOP : BIT_L;
                  end else begin
                     abort = 1'b1;
                  end
               end else if (rise_edge) begin
                  abort = 1'b1;
               end
            end
            STOP: begin
               if (rise_edge) begin
                  if (in_win(cnt_q, BURST_MIN, BURST_MAX)) begin
                     state_d   = IDLE;
                     bit_cnt_d = '0;
                     shift_d   = '0;
                     if (frame_ok) begin
                        order_d    = shift_q[23:16];
                        addr_d     = shift_q[7:0];
                        hist_d     = 1'b1;
                        order_en_d = 1'b1;
                     end else begin
                        rx_err_d = 1'b1;
                     end
                  end else begin
                     abort = 1'b1;
                  end
               end else if (fall_edge) begin
                  abort = 1'b1;
               end
            end
            REP_STOP: begin
               if (rise_edge) begin
                  if (in_win(cnt_q, BURST_MIN, BURST_MAX)) begin
                     state_d    = IDLE;
                     order_en_d = (REPEAT_EN == 1) && hist_q;
                  end else begin
                     abort = 1'b1;
                  end
               end else if (fall_edge) begin
                  abort = 1'b1;
               end
            end
            default: abort = 1'b1;
         endcase
      end

      if (abort) begin
         state_d    = IDLE;
         bit_cnt_d  = '0;
         shift_d    = '0;
         order_en_d = 1'b0;
         rx_err_d   = 1'b1;
      end
   end

   // FSM and datapath registers.
   always_ff @(posedge clk or negedge rst_int_n) begin
      if (!rst_int_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         bit_cnt_q  <= '0;
         shift_q    <= '0;
         order_q    <= '0;
         addr_q     <= '0;
         order_en_q <= 1'b0;
         rx_err_q   <= 1'b0;
         hist_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         order_q    <= order_d;
         addr_q     <= addr_d;
         order_en_q <= order_en_d;
         rx_err_q   <= rx_err_d;
         hist_q     <= hist_d;
      end
   end

   assign order    = order_q;
   assign ir_addr  = addr_q;
   assign order_en = order_en_q;
   assign rx_err   = rx_err_q;

endmodule

// File: tb/tb_ir_nec_rx.sv
// Bench for ir_nec_rx. CLK_HZ is set so one clock equals one 10 us tick,
// so all phase lengths below are in ticks. Two instances share the IR
// line: one with repeat re-emission enabled, one without.
module tb_ir_nec_rx;

   typedef struct {
      logic       is_err;
      logic [7:0] order;
      logic [7:0] addr;
   } ev_t;

   typedef struct {
      logic [7:0] addr;
      logic [7:0] cmd;
      logic [7:0] flip3;
      int         pl;
      int         ph;
      logic       exp_err;
      logic [7:0] exp_order;
      logic [7:0] exp_addr;
   } vec_t;

   logic       clk;
   logic       rst_n;
   logic       ir;
   logic [7:0] order1, addr1, order0, addr0;
   logic       en1, err1, en0, err0;

   int n_checks;
   int n_fail;
   ev_t q1[$];
   ev_t q0[$];
   vec_t vecs[4];

   ir_nec_rx #(.CLK_HZ(100_000), .REPEAT_EN(1)) u_dut1 (
      .clk      (clk),
      .rst_n    (rst_n),
      .ir_in    (ir),
      .order    (order1),
      .order_en (en1),
      .ir_addr  (addr1),
      .rx_err   (err1)
   );

   ir_nec_rx #(.CLK_HZ(100_000), .REPEAT_EN(0)) u_dut0 (
      .clk      (clk),
      .rst_n    (rst_n),
      .ir_in    (ir),
      .order    (order0),
      .order_en (en0),
      .ir_addr  (addr0),
      .rx_err   (err0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int scl(input int nom, input int pct);
      return (nom * (100 + pct) + 50) / 100;
   endfunction

   function automatic logic [31:0] mk(input logic [7:0] a, input logic [7:0] c, input logic [7:0] f);
      return {(~c) ^ f, c, ~a, a};
   endfunction

   task automatic push(input bit both, input logic is_err, input logic [7:0] o, input logic [7:0] a);
      ev_t e;
      e = '{is_err: is_err, order: o, addr: a};
      q1.push_back(e);
      if (both) q0.push_back(e);
   endtask

   // Scoreboard side: every strobe must match the oldest expected event.
   task automatic mon(input int id, input logic en, input logic err,
                      input logic [7:0] o, input logic [7:0] a);
      ev_t e;
      int  sz;
      if (en || err) begin
         sz = (id == 0) ? q0.size() : q1.size();
         check($sformatf("dut%0d_strobe_expected", id), 32'(sz > 0), 32'd1);
         check($sformatf("dut%0d_en_err_exclusive", id), 32'(en && err), 32'd0);
         if (sz > 0) begin
            if (id == 0) e = q0.pop_front();
            else         e = q1.pop_front();
            check($sformatf("dut%0d_strobe_is_err", id), 32'(err), 32'(e.is_err));
            check($sformatf("dut%0d_order", id), 32'(o), 32'(e.order));
            check($sformatf("dut%0d_ir_addr", id), 32'(a), 32'(e.addr));
         end
      end
   endtask

   always @(negedge clk) begin
      mon(1, en1, err1, order1, addr1);
      mon(0, en0, err0, order0, addr0);
   end

   task automatic hold(input logic lvl, input int n);
      ir = lvl;
      repeat (n) @(negedge clk);
   endtask

   task automatic send_frame(input logic [31:0] f, input int nbits, input int pl,
                             input int ph, input bit stop);
      hold(1'b0, scl(900, pl));
      hold(1'b1, scl(450, ph));
      for (int i = 0; i < nbits; i++) begin
         hold(1'b0, scl(56, pl));
         hold(1'b1, f[i] ? scl(169, ph) : scl(56, ph));
      end
      if (stop) begin
         hold(1'b0, scl(56, pl));
         hold(1'b1, 200);
      end
   endtask

   task automatic send_repeat();
      hold(1'b0, 900);
      hold(1'b1, 225);
      hold(1'b0, 56);
      hold(1'b1, 200);
   endtask

   task automatic drain(input int n);
      repeat (n) @(negedge clk);
      check("dut1_events_pending", 32'(q1.size()), 32'd0);
      check("dut0_events_pending", 32'(q0.size()), 32'd0);
   endtask

   initial begin
      #20_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      n_checks = 0;
      n_fail   = 0;
      ir       = 1'b1;
      rst_n    = 1'b0;

      vecs[0] = '{addr: 8'h00, cmd: 8'h15, flip3: 8'h00, pl: 0,   ph: 0,   exp_err: 1'b0, exp_order: 8'h15, exp_addr: 8'h00};
      vecs[1] = '{addr: 8'h00, cmd: 8'h15, flip3: 8'h01, pl: 0,   ph: 0,   exp_err: 1'b1, exp_order: 8'h15, exp_addr: 8'h00};
      vecs[2] = '{addr: 8'hA5, cmd: 8'h3C, flip3: 8'h00, pl: 10,  ph: -10, exp_err: 1'b0, exp_order: 8'h3C, exp_addr: 8'hA5};
      vecs[3] = '{addr: 8'h12, cmd: 8'hC3, flip3: 8'h00, pl: -10, ph: 10,  exp_err: 1'b0, exp_order: 8'hC3, exp_addr: 8'h12};

      repeat (4) @(negedge clk);
      check("reset_order", 32'(order1), 32'h0);
      check("reset_ir_addr", 32'(addr1), 32'h0);
      check("reset_order_en", 32'(en1), 32'h0);
      check("reset_rx_err", 32'(err1), 32'h0);
      check("reset_order_dut0", 32'(order0), 32'h0);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);

      // Nominal frame, corrupted complement, and +/-10% timing on every phase.
      for (int i = 0; i < 4; i++) begin
         push(1'b1, vecs[i].exp_err, vecs[i].exp_order, vecs[i].exp_addr);
         send_frame(mk(vecs[i].addr, vecs[i].cmd, vecs[i].flip3), 32, vecs[i].pl, vecs[i].ph, 1'b1);
         drain(20);
      end

      // 7 ms leader is too short; the next good frame must still decode.
      push(1'b1, 1'b1, 8'hC3, 8'h12);
      hold(1'b0, 700);
      hold(1'b1, 300);
      drain(10);
      push(1'b1, 1'b0, 8'h40, 8'h5A);
      send_frame(mk(8'h5A, 8'h40, 8'h00), 32, 0, 0, 1'b1);
      drain(20);

      // Repeat frame re-emits 0x40 only on the REPEAT_EN=1 instance.
      push(1'b0, 1'b0, 8'h40, 8'h5A);
      send_repeat();
      drain(20);

      // Line stuck high after bit 12 times out; outputs hold.
      push(1'b1, 1'b1, 8'h40, 8'h5A);
      send_frame(mk(8'h33, 8'hCC, 8'h00), 12, 0, 0, 1'b0);
      hold(1'b1, 1500);
      drain(20);

      // Reset mid-frame clears everything and emits nothing.
      send_frame(mk(8'h81, 8'h7E, 8'h00), 5, 0, 0, 1'b0);
      rst_n = 1'b0;
      ir    = 1'b1;
      repeat (2) @(negedge clk);
      check("midreset_order", 32'(order1), 32'h0);
      check("midreset_ir_addr", 32'(addr1), 32'h0);
      check("midreset_order_en", 32'(en1), 32'h0);
      check("midreset_rx_err", 32'(err1), 32'h0);
      check("midreset_order_dut0", 32'(order0), 32'h0);
      check("midreset_ir_addr_dut0", 32'(addr0), 32'h0);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);

      // Repeat with no valid frame since reset: no strobe at all.
      send_repeat();
      drain(20);

      push(1'b1, 1'b0, 8'h7E, 8'h81);
      send_frame(mk(8'h81, 8'h7E, 8'h00), 32, 0, 0, 1'b1);
      drain(20);

      repeat (300) @(negedge clk);
      check("hold_order", 32'(order1), 32'h7E);
      check("hold_ir_addr", 32'(addr1), 32'h81);
      check("hold_order_dut0", 32'(order0), 32'h7E);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
